cmd_framer: RTL

CMD_FRAMER -- requirements
Module: cmd_framer

---
 rtl/sd_cmd_pkg.sv | 57 +++++
 rtl/crc7_serial.sv | 35 +++
 rtl/cmd_framer.sv | 102 ++++++++++
 3 files changed

// File: rtl/sd_cmd_pkg.sv
// ============================================================================
//  Module      : sd_cmd_pkg
//  Description : Shared SD command framing constants, state encoding, helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_cmd_pkg;

  localparam int c_frame_bits   = 48;
  localparam int c_crc_bits     = 7;
  localparam int c_payload_bits = 40;
  localparam logic [c_crc_bits-1:0] c_crc_poly = 7'h09;

  // Bit positions within the frame, frame[0] goes on the wire first
  localparam int c_pos_start = 0;
  localparam int c_pos_tx    = 1;
  localparam int c_pos_idx   = 2;
  localparam int c_pos_arg   = 8;
  localparam int c_pos_crc   = 40;
  localparam int c_pos_end   = 47;

  localparam logic [5:0] c_last_bit = 6'd39;

  typedef logic [1:0] state_t;
  localparam state_t c_st_idle  = 2'd0;
  localparam state_t c_st_crc   = 2'd1;
  localparam state_t c_st_valid = 2'd2;

  function automatic logic [c_crc_bits-1:0] crc7_step(input logic [c_crc_bits-1:0] crc,
                                                      input logic din);
    logic fb;
    fb = crc[c_crc_bits-1] ^ din;
    return {crc[c_crc_bits-2:0], 1'b0} ^ (fb ? c_crc_poly : '0);
  endfunction

  function automatic logic [c_payload_bits-1:0] build_payload(input logic [5:0]  idx,
                                                              input logic [31:0] arg);
    logic [c_payload_bits-1:0] p;
    p = '0;
    p[c_pos_start] = 1'b0;
    p[c_pos_tx]    = 1'b1;
    for (int i = 0; i < 6; i++)  p[c_pos_idx + i] = idx[5 - i];
    for (int i = 0; i < 32; i++) p[c_pos_arg + i] = arg[31 - i];
    return p;
  endfunction

  // CRC is sent MSB first, so its bits land reversed in the LSB-first frame
  function automatic logic [c_crc_bits-1:0] reverse_crc(input logic [c_crc_bits-1:0] crc);
    logic [c_crc_bits-1:0] r;
    for (int i = 0; i < c_crc_bits; i++) r[i] = crc[c_crc_bits-1-i];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc7_serial.sv
// ============================================================================
//  Module      : crc7_serial
//  Description : Bit-serial CRC7 (x^7+x^3+1, init 0) for SD command/response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  din,
  output logic [c_crc_bits-1:0] crc
);

  logic [c_crc_bits-1:0] r_crc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc <= '0;
    end else if (clear) begin
      r_crc <= '0;
    end else if (enable) begin
      r_crc <= crc7_step(r_crc, din);
    end
  end

  assign crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/cmd_framer.sv
// ============================================================================
//  Module      : cmd_framer
//  Description : Builds a 48-bit SD command frame with serially computed CRC7.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_framer
  import sd_cmd_pkg::*;
#(
  parameter int BITS     = 48,
  parameter int CRC_BITS = 7
)
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      cmd_index,
  input  logic [31:0]     cmd_arg,
  input  logic            frame_ready,
  output logic            busy,
  output logic            frame_valid,
  output logic [BITS-1:0] frame
);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [5:0]                r_count;
  logic [c_payload_bits-1:0] r_payload;
  logic [BITS-1:0]           r_frame;
  logic [CRC_BITS-1:0]       w_crc;
  logic [CRC_BITS-1:0]       w_crc_next;
  logic [c_frame_bits-1:0]   w_frame_next;
  logic                      w_capture;
  logic                      w_crc_en;
  logic                      w_last;
  logic                      w_din;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:  if (start)       w_state_next = c_st_crc;
      c_st_crc:   if (w_last)      w_state_next = c_st_valid;
      c_st_valid: if (frame_ready) w_state_next = c_st_idle;
      default:                     w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    busy        = (r_state != c_st_idle);
    frame_valid = (r_state == c_st_valid);
    w_capture   = (r_state == c_st_idle) && start;
    w_crc_en    = (r_state == c_st_crc);
    w_last      = (r_state == c_st_crc) && (r_count == c_last_bit);
  end

  assign w_din      = r_payload[r_count];
  assign w_crc_next = crc7_step(w_crc, w_din);

  // The frame is loaded with the CRC that includes the final payload bit
  assign w_frame_next = {1'b1, reverse_crc(w_crc_next), r_payload};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_payload <= '0;
      r_frame   <= '1;
    end else begin
      if (w_capture) begin
        r_payload <= build_payload(cmd_index, cmd_arg);
        r_count   <= '0;
      end else if (w_crc_en && !w_last) begin
        r_count <= r_count + 6'd1;
      end
      if (w_last) begin
        r_frame <= w_frame_next;
      end
    end
  end

  crc7_serial u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_capture),
    .enable (w_crc_en),
    .din    (w_din),
    .crc    (w_crc)
  );

  assign frame = r_frame;

endmodule

`default_nettype wire
